// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues in-order requests to instruction memory,
// buffers returned words with their PCs in a small FIFO and presents one
// instruction per cycle to decode. Handles redirects and halt/resume.
//
// state  | meaning
// RUN    | fetching and delivering instructions
// DRAIN  | halt seen, discarding responses still in flight
// HALTED | idle until resume
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic [31:0] halt_pc,
    input  logic        resume,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        halted
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state;
    logic          active;
    logic [31:0]   fetch_pc;
    logic [31:0]   resume_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic [31:0]   fifo_word [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] fifo_rd;
    logic [PW-1:0] fifo_wr;
    logic [CW-1:0] fifo_count;

    // PC of every in-flight request, in issue order; its occupancy equals outstanding
    logic [31:0]   pcq [DEPTH];
    logic [PW-1:0] pcq_rd;
    logic [PW-1:0] pcq_wr;

    logic          in_run;
    logic [CW:0]   occupancy;
    logic          fire;
    logic          pop;
    logic          push;
    logic          flush;
    logic [CW-1:0] out_after;

    assign in_run    = (state == RUN);
    assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req  = active && in_run && (occupancy < DEPTH_W) && !redirect_valid && !halt;
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;

    assign inst_valid = in_run && (fifo_count != '0) && !redirect_valid;
    assign inst       = inst_valid ? fifo_word[fifo_rd] : NOP_INST;
    assign inst_pc    = inst_valid ? fifo_pc[fifo_rd] : 32'h0;
    assign halted     = (state == HALTED);

    assign pop       = inst_valid && !stall;
    assign flush     = in_run && (halt || redirect_valid);
    // a word is kept only when it is not owed to an earlier flush and nothing flushes now
    assign push      = imem_rvalid && in_run && (drop == '0) && !flush;
    assign out_after = outstanding - CW'(imem_rvalid);

    // control FSM: fetch PC, outstanding/drop accounting, halt and resume sequencing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            active      <= 1'b0;
            fetch_pc    <= RESET_PC;
            resume_pc   <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid);
            if (fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            case (state)
                RUN: begin
                    if (halt) begin
                        resume_pc <= halt_pc + 32'd4;
                        drop      <= '0;
                        state     <= (out_after != '0) ? DRAIN : HALTED;
                    end else if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        drop     <= out_after;
                    end else if (imem_rvalid && (drop != '0)) begin
                        drop <= drop - CW'(1);
                    end
                end
                DRAIN: begin
                    if (out_after == '0) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        fetch_pc <= redirect_valid ? redirect_pc : resume_pc;
                        state    <= RUN;
                    end else if (redirect_valid) begin
                        resume_pc <= redirect_pc;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // FIFO and PC-queue pointers; a flush empties the FIFO but in-flight PCs stay queued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_rd    <= '0;
            fifo_wr    <= '0;
            fifo_count <= '0;
            pcq_rd     <= '0;
            pcq_wr     <= '0;
        end else begin
            if (flush) begin
                fifo_rd    <= '0;
                fifo_wr    <= '0;
                fifo_count <= '0;
            end else begin
                if (push) begin
                    fifo_wr <= fifo_wr + PW'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + PW'(1);
                end
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
            if (fire) begin
                pcq_wr <= pcq_wr + PW'(1);
            end
            if (imem_rvalid) begin
                pcq_rd <= pcq_rd + PW'(1);
            end
        end
    end

    // storage arrays carry no reset; valid entries are tracked by the pointers above
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_word[fifo_wr] <= imem_rdata;
            fifo_pc[fifo_wr]   <= pcq[pcq_rd];
        end
        if (fire) begin
            pcq[pcq_wr] <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed scenarios followed by randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_inst_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] halt_pc = 32'h0;
    logic        resume = 1'b0;
    logic        stall = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        halted;

    inst_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halt_pc        (halt_pc),
        .resume         (resume),
        .stall          (stall),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model: in-order outstanding requests, each marked stale once a flush orphans it
    logic [31:0] q_addr [$];
    int          q_due  [$];
    bit          q_stale[$];
    // words returned and not yet taken by decode, in program order
    logic [31:0] buf_pc [$];
    logic [31:0] hs_log [$];
    logic [31:0] pop_log[$];

    bit          m_started;
    bit          m_draining;
    bit          m_halted;
    logic [31:0] exp_fetch;
    logic [31:0] m_resume;
    int          cyc;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          first_valid_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        if (r[31:30] == 2'b00) return 32'hFFFF_FFF0 + {28'd0, r[3:2], 2'b00};
        return {r[29:2], 4'b0000};
    endfunction

    task automatic clear_model();
        q_addr.delete();
        q_due.delete();
        q_stale.delete();
        buf_pc.delete();
        hs_log.delete();
        pop_log.delete();
        m_started       = 1'b0;
        m_draining      = 1'b0;
        m_halted        = 1'b0;
        exp_fetch       = RESET_PC;
        m_resume        = RESET_PC;
        first_valid_cyc = -1;
        cyc             = 0;
    endtask

    task automatic reset_dut();
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        resume         = 1'b0;
        stall          = 1'b0;
        #1;
        chk("reset_inst_valid", 32'(inst_valid), 32'd0);
        chk("reset_inst", inst, NOP);
        chk("reset_inst_pc", inst_pc, 32'h0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_imem_req", 32'(imem_req), 32'd0);
        chk("reset_imem_addr", imem_addr, RESET_PC);
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // one clock cycle: called at a negedge with inputs already set
    task automatic do_cycle();
        bit          resp;
        bit          running;
        bit          exp_req;
        bit          exp_valid;
        bit          hs;
        bit          take;
        bit          flush;
        bit          stale;
        logic [31:0] raddr;
        resp        = (q_addr.size() > 0) && (q_due[0] <= cyc);
        imem_rvalid = resp;
        imem_rdata  = resp ? mem_word(q_addr[0]) : 32'hDEAD_BEEF;
        #1;
        running   = !m_draining && !m_halted;
        exp_req   = m_started && running && (q_addr.size() + buf_pc.size() < DEPTH)
                    && !redirect_valid && !halt;
        exp_valid = running && (buf_pc.size() > 0) && !redirect_valid;
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (inst_valid && exp_valid) begin
            chk("inst_pc", inst_pc, buf_pc[0]);
            chk("inst", inst, mem_word(buf_pc[0]));
        end else if (!inst_valid) begin
            chk("inst_nop", inst, NOP);
            chk("inst_pc_zero", inst_pc, 32'h0);
        end
        if (inst_valid && exp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        hs = imem_req && imem_gnt;
        if (hs) chk("imem_addr", imem_addr, exp_fetch);

        flush = running && (halt || redirect_valid);
        take  = exp_valid && !stall;
        if (take) begin
            pop_log.push_back(buf_pc[0]);
            void'(buf_pc.pop_front());
        end
        if (resp) begin
            raddr = q_addr.pop_front();
            void'(q_due.pop_front());
            stale = q_stale.pop_front();
            if (!stale && running && !flush) buf_pc.push_back(raddr);
        end
        if (hs) begin
            hs_log.push_back(imem_addr);
            q_addr.push_back(imem_addr);
            q_due.push_back(cyc + $urandom_range(lat_hi, lat_lo));
            q_stale.push_back(1'b0);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (running && halt) begin
            buf_pc.delete();
            foreach (q_stale[i]) q_stale[i] = 1'b1;
            m_resume = halt_pc + 32'd4;
            if (q_addr.size() > 0) m_draining = 1'b1;
            else m_halted = 1'b1;
        end else if (running && redirect_valid) begin
            buf_pc.delete();
            foreach (q_stale[i]) q_stale[i] = 1'b1;
            exp_fetch = redirect_pc;
        end else if (m_draining) begin
            if (q_addr.size() == 0) begin
                m_draining = 1'b0;
                m_halted   = 1'b1;
            end
        end else if (m_halted) begin
            if (resume) begin
                exp_fetch = redirect_valid ? redirect_pc : m_resume;
                m_halted  = 1'b0;
            end else if (redirect_valid) begin
                m_resume = redirect_pc;
            end
        end
        m_started = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_halted(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (halted) break;
            do_cycle();
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    task automatic resume_and_check(input string tag, input bit with_redir,
                                    input logic [31:0] rpc, input logic [31:0] exp_addr);
        hs_log.delete();
        resume         = 1'b1;
        redirect_valid = with_redir;
        redirect_pc    = rpc;
        do_cycle();
        resume         = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (hs_log.size() > 0) break;
            do_cycle();
        end
        chk(tag, (hs_log.size() > 0) ? hs_log[0] : 32'hFFFF_FFFF, exp_addr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_dut();

        // reset and first fetches
        imem_gnt = 1'b1;
        lat_lo   = 1;
        lat_hi   = 1;
        for (int i = 0; i < 12; i++) do_cycle();
        chk("t1_first_valid_cycle", 32'(first_valid_cyc), 32'd3);
        chk("t1_hs_count", 32'(hs_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < hs_log.size(); i++)
            chk("t1_addr", hs_log[i], RESET_PC + 32'(4 * i));

        // backpressure
        stall = 1'b1;
        for (int i = 0; i < 4; i++) do_cycle();
        #1;
        chk("t2_req_while_full", 32'(imem_req), 32'd0);
        do_cycle();
        stall = 1'b0;
        for (int i = 0; i < 12; i++) do_cycle();
        chk("t2_pop_count", 32'(pop_log.size() >= 8), 32'd1);
        foreach (pop_log[i]) chk("t2_seq", pop_log[i], RESET_PC + 32'(4 * i));

        // redirect with two requests in flight
        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 30; i++) begin
            if (q_addr.size() == 2 && buf_pc.size() == 0) break;
            do_cycle();
        end
        chk("t3_two_outstanding", 32'(q_addr.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        pop_log.delete();
        do_cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (pop_log.size() > 0) break;
            do_cycle();
        end
        chk("t3_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h0000_0200);

        // halt with one request in flight, drain, resume
        for (int i = 0; i < 30; i++) begin
            if (q_addr.size() == 1 && q_due[0] > cyc) break;
            do_cycle();
        end
        chk("t4_one_outstanding", 32'(q_addr.size()), 32'd1);
        halt    = 1'b1;
        halt_pc = 32'h0000_0110;
        do_cycle();
        halt = 1'b0;
        chk("t4_draining_not_halted", 32'(halted), 32'd0);
        wait_halted("t4_halted");
        resume_and_check("t4_resume_addr", 1'b0, 32'h0, 32'h0000_0114);

        // halt and redirect together: halt wins
        for (int i = 0; i < 3; i++) do_cycle();
        halt           = 1'b1;
        halt_pc        = 32'h0000_0300;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0500;
        do_cycle();
        halt           = 1'b0;
        redirect_valid = 1'b0;
        wait_halted("t5_halted");
        resume_and_check("t5_resume_addr", 1'b0, 32'h0, 32'h0000_0304);

        // redirect while halted sets the resume point; a same-cycle redirect overrides it
        halt    = 1'b1;
        halt_pc = 32'h0000_0400;
        do_cycle();
        halt = 1'b0;
        wait_halted("t7_halted");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0600;
        do_cycle();
        redirect_valid = 1'b0;
        resume_and_check("t7_resume_redirected", 1'b0, 32'h0, 32'h0000_0600);
        halt    = 1'b1;
        halt_pc = 32'h0000_0440;
        do_cycle();
        halt = 1'b0;
        wait_halted("t7_halted_again");
        resume_and_check("t7_resume_with_redirect", 1'b1, 32'h0000_0700, 32'h0000_0700);

        // address wrap
        lat_lo = 1;
        lat_hi = 2;
        for (int i = 0; i < 3; i++) do_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        hs_log.delete();
        do_cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (hs_log.size() >= 2) break;
            do_cycle();
        end
        chk("t6_addr_top", (hs_log.size() > 0) ? hs_log[0] : 32'h1, 32'hFFFF_FFFC);
        chk("t6_addr_wrap", (hs_log.size() > 1) ? hs_log[1] : 32'h1, 32'h0000_0000);

        // randomized traffic, with a reset in the middle of it
        lat_lo = 1;
        lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_dut();
            imem_gnt       = ($urandom_range(9, 0) < 7);
            stall          = ($urandom_range(9, 0) < 3);
            redirect_valid = 1'b0;
            halt           = 1'b0;
            resume         = 1'b0;
            if (!m_draining) begin
                if ($urandom_range(99, 0) < 3) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = rand_pc();
                end
                if ($urandom_range(99, 0) < 2) begin
                    halt    = 1'b1;
                    halt_pc = rand_pc();
                end
            end
            if (m_halted && $urandom_range(9, 0) < 3) resume = 1'b1;
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
